// File: rtl/mem_stage_sramlike.sv
// MEM pipeline stage: issues one data access at a time over an SRAM-like
// req/addr_ok + data_ok handshake, aligns/extends loads, and drains flushed responses.
module mem_stage_sramlike #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEST_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ws_allowin,
  output logic                  ms_allowin,
  input  logic                  es_to_ms_valid,
  input  logic                  es_mem_en,
  input  logic                  es_mem_we,
  input  logic [1:0]            es_mem_size,
  input  logic                  es_ld_sign,
  input  logic [DATA_W-1:0]     es_alu_result,
  input  logic [DATA_W-1:0]     es_wdata,
  input  logic                  es_gr_we,
  input  logic [DEST_W-1:0]     es_dest,
  input  logic [31:0]           es_pc,
  input  logic                  flush,
  output logic                  ms_to_ws_valid,
  output logic                  ms_gr_we,
  output logic [DEST_W-1:0]     ms_dest,
  output logic [DATA_W-1:0]     ms_final_result,
  output logic [31:0]           ms_pc,
  output logic                  ms_fwd_we,
  output logic                  ms_fwd_ready,
  output logic                  data_sram_req,
  output logic                  data_sram_wr,
  output logic [1:0]            data_sram_size,
  output logic [DATA_W/8-1:0]   data_sram_wstrb,
  output logic [ADDR_W-1:0]     data_sram_addr,
  output logic [DATA_W-1:0]     data_sram_wdata,
  input  logic                  data_sram_addr_ok,
  input  logic                  data_sram_data_ok,
  input  logic [DATA_W-1:0]     data_sram_rdata
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DROP} state_t;
  state_t r_state, w_state_nxt;

  logic              r_valid;
  logic              r_mem_en, r_mem_we, r_ld_sign, r_gr_we;
  logic [1:0]        r_mem_size;
  logic [DATA_W-1:0] r_alu, r_wdata, r_ld_result;
  logic [DEST_W-1:0] r_dest;
  logic [31:0]       r_pc;

  logic              w_ready_go, w_latch, w_req, w_capture;
  logic [OFF_W-1:0]  w_off;
  logic [DATA_W-1:0] w_rsh, w_lmask, w_ltop, w_ld_ext, w_wdata;
  logic              w_lneg;
  logic [STRB_W-1:0] w_smask;

  assign w_ready_go = !r_mem_en || (r_state == S_DONE);
  assign ms_allowin = (r_state != S_DROP) && !flush && (!r_valid || (w_ready_go && ws_allowin));
  assign w_latch    = es_to_ms_valid && ms_allowin;
  assign w_req      = (r_state == S_REQ);

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: if (!flush && w_latch && es_mem_en) w_state_nxt = S_REQ;
      S_REQ: begin
        if (flush)                  w_state_nxt = data_sram_addr_ok ? S_DROP : S_IDLE;
        else if (data_sram_addr_ok) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          w_state_nxt = flush ? S_IDLE : S_DONE;
          w_capture   = !flush;
        end else if (flush) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DONE: begin
        if (flush)           w_state_nxt = S_IDLE;
        else if (ws_allowin) w_state_nxt = (w_latch && es_mem_en) ? S_REQ : S_IDLE;
      end
      S_DROP:  if (data_sram_data_ok) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_size  <= 2'd0;
      r_ld_sign   <= 1'b0;
      r_alu       <= '0;
      r_wdata     <= '0;
      r_gr_we     <= 1'b0;
      r_dest      <= '0;
      r_pc        <= '0;
      r_ld_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush)           r_valid <= 1'b0;
      else if (ms_allowin) r_valid <= es_to_ms_valid;
      if (w_latch) begin
        r_mem_en   <= es_mem_en;
        r_mem_we   <= es_mem_we;
        r_mem_size <= es_mem_size;
        r_ld_sign  <= es_ld_sign;
        r_alu      <= es_alu_result;
        r_wdata    <= es_wdata;
        r_gr_we    <= es_gr_we;
        r_dest     <= es_dest;
        r_pc       <= es_pc;
      end
      if (w_capture) r_ld_result <= w_ld_ext;
    end
  end

  // Load path: the size mask's top bit doubles as the sign-bit selector, so any width works.
  assign w_off    = r_alu[OFF_W-1:0];
  assign w_rsh    = data_sram_rdata >> {w_off, 3'b000};
  assign w_lmask  = (DATA_W'(1) << (8 << r_mem_size)) - DATA_W'(1);
  assign w_ltop   = w_lmask ^ (w_lmask >> 1);
  assign w_lneg   = r_ld_sign && (|(w_rsh & w_ltop));
  assign w_ld_ext = (w_rsh & w_lmask) | (w_lneg ? ~w_lmask : '0);

  assign w_smask  = (STRB_W'(1) << (1 << r_mem_size)) - STRB_W'(1);

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < STRB_W; i++) begin
      case (r_mem_size)
        2'd0:    w_wdata[i*8 +: 8] = r_wdata[7:0];
        2'd1:    w_wdata[i*8 +: 8] = r_wdata[(i%2)*8 +: 8];
        2'd2:    w_wdata[i*8 +: 8] = r_wdata[(i%4)*8 +: 8];
        default: w_wdata[i*8 +: 8] = r_wdata[(i%8)*8 +: 8];
      endcase
    end
  end

  // Bus fields derive only from latched state, so they stay frozen until addr_ok.
  assign data_sram_req   = w_req;
  assign data_sram_wr    = w_req && r_mem_we;
  assign data_sram_size  = w_req ? r_mem_size : 2'd0;
  assign data_sram_addr  = w_req ? r_alu[ADDR_W-1:0] : '0;
  assign data_sram_wstrb = (w_req && r_mem_we) ? (w_smask << w_off) : '0;
  assign data_sram_wdata = (w_req && r_mem_we) ? w_wdata : '0;

  assign ms_to_ws_valid  = r_valid && w_ready_go;
  assign ms_gr_we        = r_gr_we;
  assign ms_dest         = r_dest;
  assign ms_pc           = r_pc;
  assign ms_final_result = (r_mem_en && !r_mem_we) ? r_ld_result : r_alu;
  assign ms_fwd_we       = r_valid && r_gr_we;
  assign ms_fwd_ready    = r_valid && w_ready_go;
endmodule

// File: tb/tb_mem_stage_sramlike.sv
// Scoreboarded bench for mem_stage_sramlike: 32-bit instance with a delay-programmable
// memory responder, plus a 64-bit instance for wide-lane load alignment.
module tb_mem_stage_sramlike;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ws_allowin, flush;
  logic        es_to_ms_valid, es_mem_en, es_mem_we, es_ld_sign, es_gr_we;
  logic [1:0]  es_mem_size;
  logic [31:0] es_alu_result, es_wdata, es_pc;
  logic [4:0]  es_dest;
  logic        ms_allowin, ms_to_ws_valid, ms_gr_we, ms_fwd_we, ms_fwd_ready;
  logic [4:0]  ms_dest;
  logic [31:0] ms_final_result, ms_pc;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

  logic        v64, aok64, dok64;
  logic [63:0] alu64, wd64, rd64;
  logic        a64_allowin, a64_valid, a64_gr_we, a64_fwd_we, a64_fwd_ready;
  logic        a64_req, a64_wr;
  logic [1:0]  a64_size;
  logic [4:0]  a64_dest;
  logic [63:0] a64_result, a64_wdata;
  logic [31:0] a64_pc, a64_addr;
  logic [7:0]  a64_wstrb;

  mem_stage_sramlike #(.DATA_W(32), .ADDR_W(32), .DEST_W(5)) dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_mem_en(es_mem_en), .es_mem_we(es_mem_we),
    .es_mem_size(es_mem_size), .es_ld_sign(es_ld_sign), .es_alu_result(es_alu_result),
    .es_wdata(es_wdata), .es_gr_we(es_gr_we), .es_dest(es_dest), .es_pc(es_pc),
    .flush(flush), .ms_to_ws_valid(ms_to_ws_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_final_result(ms_final_result), .ms_pc(ms_pc), .ms_fwd_we(ms_fwd_we),
    .ms_fwd_ready(ms_fwd_ready), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata)
  );

  mem_stage_sramlike #(.DATA_W(64), .ADDR_W(32), .DEST_W(5)) dut64 (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(a64_allowin),
    .es_to_ms_valid(v64), .es_mem_en(es_mem_en), .es_mem_we(es_mem_we),
    .es_mem_size(es_mem_size), .es_ld_sign(es_ld_sign), .es_alu_result(alu64),
    .es_wdata(wd64), .es_gr_we(es_gr_we), .es_dest(es_dest), .es_pc(es_pc),
    .flush(flush), .ms_to_ws_valid(a64_valid), .ms_gr_we(a64_gr_we), .ms_dest(a64_dest),
    .ms_final_result(a64_result), .ms_pc(a64_pc), .ms_fwd_we(a64_fwd_we),
    .ms_fwd_ready(a64_fwd_ready), .data_sram_req(a64_req), .data_sram_wr(a64_wr),
    .data_sram_size(a64_size), .data_sram_wstrb(a64_wstrb),
    .data_sram_addr(a64_addr), .data_sram_wdata(a64_wdata),
    .data_sram_addr_ok(aok64), .data_sram_data_ok(dok64), .data_sram_rdata(rd64)
  );

  typedef struct {logic [31:0] res; logic [4:0] dest; logic [31:0] pc; logic gr_we;} wb_t;
  typedef struct {logic wr; logic [1:0] size; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata;} bus_t;
  wb_t  rq[$];
  bus_t bq[$];
  logic [63:0] q64[$];

  int errors = 0, checks = 0;
  int aok_dly = 0, dok_dly = 0;
  logic [31:0] rd_val = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_wb(input logic [31:0] r, input logic [4:0] d, input logic [31:0] p, input logic g);
    wb_t e;
    e.res = r; e.dest = d; e.pc = p; e.gr_we = g;
    rq.push_back(e);
  endtask

  task automatic push_bus(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [3:0] st, input logic [31:0] wd);
    bus_t b;
    b.wr = wr; b.size = sz; b.addr = a; b.wstrb = st; b.wdata = wd;
    bq.push_back(b);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents an EX op and holds it until MEM takes it; returns at latch edge + 1.
  task automatic issue(input logic men, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] alu, input logic [31:0] wd, input logic gw,
                       input logic [4:0] dst, input logic [31:0] pc);
    int n;
    es_mem_en = men; es_mem_we = we; es_mem_size = sz; es_ld_sign = sg;
    es_alu_result = alu; es_wdata = wd; es_gr_we = gw; es_dest = dst; es_pc = pc;
    es_to_ms_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ms_allowin && n < 100);
    if (!ms_allowin) chk("issue_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!ms_to_ws_valid && n < 60);
    if (!ms_to_ws_valid) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  // Memory model: addr_ok after aok_dly req cycles, data_ok dok_dly cycles after the one following addr_ok.
  initial begin
    int phase, cnt;
    phase = 0; cnt = 0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    forever begin
      @(posedge clk); #2;
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
      if (reset) begin
        phase = 0; cnt = 0;
      end else if (phase == 0) begin
        if (!data_sram_req) cnt = 0;
        else if (cnt == aok_dly) begin data_sram_addr_ok = 1'b1; phase = 1; cnt = 0; end
        else cnt++;
      end else begin
        if (cnt == dok_dly) begin
          data_sram_data_ok = 1'b1; data_sram_rdata = rd_val; phase = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  // Monitor: WB results, accepted bus requests, and bus stability while stalled.
  initial begin
    wb_t  e;
    bus_t b, pb;
    logic pend;
    logic [63:0] e64;
    pend = 1'b0;
    pb = '{wr: 1'b0, size: 2'd0, addr: 32'd0, wstrb: 4'd0, wdata: 32'd0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ms_to_ws_valid && ws_allowin) begin
          if (rq.size() == 0) chk("wb_unexpected", 64'd1, 64'd0);
          else begin
            e = rq.pop_front();
            chk("wb_result", ms_final_result, e.res);
            chk("wb_dest", ms_dest, e.dest);
            chk("wb_pc", ms_pc, e.pc);
            chk("wb_gr_we", ms_gr_we, e.gr_we);
          end
        end
        if (data_sram_req && data_sram_addr_ok) begin
          if (bq.size() == 0) chk("bus_unexpected", 64'd1, 64'd0);
          else begin
            b = bq.pop_front();
            chk("bus_wr", data_sram_wr, b.wr);
            chk("bus_size", data_sram_size, b.size);
            chk("bus_addr", data_sram_addr, b.addr);
            if (b.wr) begin
              chk("bus_wstrb", data_sram_wstrb, b.wstrb);
              chk("bus_wdata", data_sram_wdata, b.wdata);
            end
          end
        end
        if (pend) begin
          chk("hold_req", data_sram_req, 1'b1);
          chk("hold_addr", data_sram_addr, pb.addr);
          chk("hold_size", data_sram_size, pb.size);
          chk("hold_wr", data_sram_wr, pb.wr);
        end
        pend = data_sram_req && !data_sram_addr_ok && !flush;
        pb.addr = data_sram_addr; pb.size = data_sram_size; pb.wr = data_sram_wr;
        if (a64_valid && ws_allowin) begin
          if (q64.size() == 0) chk("wb64_unexpected", 64'd1, 64'd0);
          else begin
            e64 = q64.pop_front();
            chk("wb64_result", a64_result, e64);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, nreq;
    reset = 1'b1; ws_allowin = 1'b1; flush = 1'b0;
    es_to_ms_valid = 1'b0; es_mem_en = 1'b0; es_mem_we = 1'b0; es_mem_size = 2'd0;
    es_ld_sign = 1'b0; es_alu_result = '0; es_wdata = '0; es_gr_we = 1'b0;
    es_dest = '0; es_pc = '0;
    v64 = 1'b0; alu64 = '0; wd64 = '0; rd64 = '0; aok64 = 1'b0; dok64 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_outs", |{ms_to_ws_valid, ms_gr_we, ms_dest, ms_final_result, ms_pc, ms_fwd_we,
                      ms_fwd_ready, data_sram_req, data_sram_wr, data_sram_size,
                      data_sram_wstrb, data_sram_addr, data_sram_wdata}, 1'b0);
    chk("rst64_allowin", a64_allowin, 1'b1);
    chk("rst64_outs", |{a64_valid, a64_gr_we, a64_dest, a64_result, a64_pc, a64_fwd_we,
                        a64_fwd_ready, a64_req, a64_wr, a64_size, a64_wstrb, a64_addr,
                        a64_wdata}, 1'b0);
    @(posedge clk); #1;

    // Signed byte load, single-cycle handshakes: 3-cycle latch-to-valid.
    aok_dly = 0; dok_dly = 0; rd_val = 32'h80AA_BB11;
    push_bus(1'b0, 2'd0, 32'h1003, 4'h0, 32'h0);
    push_wb(32'hFFFF_FF80, 5'd3, 32'hBFC0_0000, 1'b1);
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 1'b1, 5'd3, 32'hBFC0_0000);
    wait_valid(n);
    chk("lb_latency", n, 3);
    cyc(1);

    // Stores: half, byte, word.
    push_bus(1'b1, 2'd1, 32'h2002, 4'b1100, 32'h1234_1234);
    push_wb(32'h2002, 5'd0, 32'hBFC0_0004, 1'b0);
    issue(1'b1, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_1234, 1'b0, 5'd0, 32'hBFC0_0004);
    wait_valid(n);
    chk("sh_latency", n, 3);
    cyc(1);
    push_bus(1'b1, 2'd0, 32'h0001, 4'b0010, 32'hABAB_ABAB);
    push_wb(32'h0001, 5'd0, 32'hBFC0_0008, 1'b0);
    issue(1'b1, 1'b1, 2'd0, 1'b0, 32'h0001, 32'hFFFF_FFAB, 1'b0, 5'd0, 32'hBFC0_0008);
    wait_valid(n); cyc(1);
    push_bus(1'b1, 2'd2, 32'h0008, 4'b1111, 32'h1122_3344);
    push_wb(32'h0008, 5'd0, 32'hBFC0_000C, 1'b0);
    issue(1'b1, 1'b1, 2'd2, 1'b0, 32'h0008, 32'h1122_3344, 1'b0, 5'd0, 32'hBFC0_000C);
    wait_valid(n); cyc(1);

    // Half loads from the upper lane, unsigned then signed.
    rd_val = 32'h8001_7FFF;
    push_bus(1'b0, 2'd1, 32'h10A2, 4'h0, 32'h0);
    push_wb(32'h0000_8001, 5'd4, 32'hBFC0_0010, 1'b1);
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h10A2, 32'h0, 1'b1, 5'd4, 32'hBFC0_0010);
    wait_valid(n); cyc(1);
    push_bus(1'b0, 2'd1, 32'h10A2, 4'h0, 32'h0);
    push_wb(32'hFFFF_8001, 5'd5, 32'hBFC0_0014, 1'b1);
    issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h10A2, 32'h0, 1'b1, 5'd5, 32'hBFC0_0014);
    wait_valid(n); cyc(1);

    // Word load with slow addr_ok (4 cycles) and data_ok 3 cycles after it.
    aok_dly = 4; dok_dly = 2; rd_val = 32'hCAFE_F00D;
    push_bus(1'b0, 2'd2, 32'h3000, 4'h0, 32'h0);
    push_wb(32'hCAFE_F00D, 5'd6, 32'hBFC0_0018, 1'b1);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 1'b1, 5'd6, 32'hBFC0_0018);
    n = 0; nreq = 0;
    do begin
      @(negedge clk); n++;
      if (data_sram_req) nreq++;
    end while (!data_sram_data_ok && n < 50);
    chk("lw_req_cycles", nreq, 5);
    chk("lw_fwd_we", ms_fwd_we, 1'b1);
    chk("lw_fwd_ready_at_dok", ms_fwd_ready, 1'b0);
    @(negedge clk);
    chk("lw_fwd_ready_after", ms_fwd_ready, 1'b1);
    cyc(1);

    // Flush in WAIT; response drains 2 cycles later; next op waits for DROP to end.
    aok_dly = 0; dok_dly = 2; rd_val = 32'h7777_7777;
    push_bus(1'b0, 2'd2, 32'h4000, 4'h0, 32'h0);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 1'b1, 5'd8, 32'hBFC0_001C);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    es_mem_en = 1'b0; es_alu_result = 32'h0000_5555; es_gr_we = 1'b1; es_dest = 5'd7;
    es_pc = 32'hBFC0_0020; es_to_ms_valid = 1'b1;
    push_wb(32'h0000_5555, 5'd7, 32'hBFC0_0020, 1'b1);
    @(negedge clk);
    chk("drop_allowin_0", ms_allowin, 1'b0);
    chk("drop_no_valid", ms_to_ws_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_allowin_dok", ms_allowin, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_allowin_after", ms_allowin, 1'b1);
    @(posedge clk); #1 es_to_ms_valid = 1'b0;
    wait_valid(n);
    chk("post_drop_latency", n, 1);
    cyc(1);

    // ALU op stalled by WB for 2 cycles; following load waits behind it.
    ws_allowin = 1'b0; rd_val = 32'h0000_5A00; dok_dly = 0;
    push_wb(32'h0000_ABCD, 5'd9, 32'hBFC0_0024, 1'b1);
    issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_ABCD, 32'h0, 1'b1, 5'd9, 32'hBFC0_0024);
    es_mem_en = 1'b1; es_mem_we = 1'b0; es_mem_size = 2'd0; es_ld_sign = 1'b0;
    es_alu_result = 32'h6001; es_gr_we = 1'b1; es_dest = 5'd10; es_pc = 32'hBFC0_0028;
    es_to_ms_valid = 1'b1;
    push_bus(1'b0, 2'd0, 32'h6001, 4'h0, 32'h0);
    push_wb(32'h0000_005A, 5'd10, 32'hBFC0_0028, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_result", ms_final_result, 32'h0000_ABCD);
      chk("stall_allowin", ms_allowin, 1'b0);
      chk("stall_valid", ms_to_ws_valid, 1'b1);
      @(posedge clk); #1;
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("stall_release_allowin", ms_allowin, 1'b1);
    @(posedge clk); #1 es_to_ms_valid = 1'b0;
    wait_valid(n);
    cyc(1);

    // 64-bit datapath: unsigned word load from the upper lane.
    es_mem_en = 1'b1; es_mem_we = 1'b0; es_mem_size = 2'd2; es_ld_sign = 1'b0;
    es_gr_we = 1'b1; es_dest = 5'd11; es_pc = 32'hBFC0_002C;
    alu64 = 64'h0000_0000_0000_1004; v64 = 1'b1;
    q64.push_back(64'h0000_0000_DEAD_BEEF);
    @(posedge clk); #1 v64 = 1'b0;
    n = 0;
    while (!a64_req && n < 20) begin @(posedge clk); #1; n++; end
    chk("d64_req", a64_req, 1'b1);
    chk("d64_addr", a64_addr, 32'h1004);
    chk("d64_size", a64_size, 2'd2);
    aok64 = 1'b1;
    @(posedge clk); #1 aok64 = 1'b0;
    dok64 = 1'b1; rd64 = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1 dok64 = 1'b0;
    @(negedge clk);
    chk("d64_valid", a64_valid, 1'b1);
    cyc(3);

    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    chk("q64_drained", q64.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage_sramlike.md
Name: mem_stage_sramlike

Overview:
- Parametrised MEM pipeline stage for the in-order MIPS core. Sits between EX and WB.
- Issues the data-memory access over an SRAM-like split handshake (req/addr_ok, then data_ok) instead of single-cycle synchronous SRAM.
- Aligns and extends load data for any datapath width, and drives forwarding/stall information to ID.
- Supports pipeline flush with in-flight response draining. One outstanding access at a time.

Parameters:
- DATA_W, 32, datapath and memory data width; legal values are 32 and 64.
- ADDR_W, 32, data-memory address width.
- DEST_W, 5, register destination index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ws_allowin  in  1  WB can accept this cycle
- ms_allowin  out  1  MEM can accept this cycle
- es_to_ms_valid  in  1  EX presents an instruction
- es_mem_en  in  1  instruction accesses memory
- es_mem_we  in  1  1 = store, 0 = load
- es_mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (DATA_W=64 only)
- es_ld_sign  in  1  sign-extend load result
- es_alu_result  in  DATA_W  ALU result, also the memory address (low ADDR_W bits)
- es_wdata  in  DATA_W  store data, right-aligned
- es_gr_we  in  1  writes the register file
- es_dest  in  DEST_W  destination register
- es_pc  in  32  instruction PC
- flush  in  1  discard MEM contents (exception/eret)
- ms_to_ws_valid  out  1  result valid to WB
- ms_gr_we  out  1  register write enable to WB
- ms_dest  out  DEST_W  destination to WB
- ms_final_result  out  DATA_W  load data or ALU result
- ms_pc  out  32  PC to WB
- ms_fwd_we  out  1  ms_valid & ms_gr_we, for ID hazard check
- ms_fwd_ready  out  1  ms_final_result is valid for forwarding
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  request is a write
- data_sram_size  out  2  equals held mem_size
- data_sram_wstrb  out  DATA_W/8  byte strobes
- data_sram_addr  out  ADDR_W  byte address
- data_sram_wdata  out  DATA_W  lane-replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  read data / write acknowledge returned
- data_sram_rdata  in  DATA_W  read data

Behaviour:
- Reset: state IDLE, ms_valid=0; all outputs 0 except ms_allowin=1.
- ms_allowin = (state != DROP) && !flush && (!ms_valid || (ready_go && ws_allowin)).
- Fields are latched when es_to_ms_valid && ms_allowin.
- ms_to_ws_valid = ms_valid && ready_go.
- Non-memory instruction: ready_go=1 in the cycle it is latched. Result = alu_result. No bus activity.
- Memory FSM states:
  - IDLE: on latching a memory op, go to REQ.
  - REQ: data_sram_req=1. On addr_ok, go to WAIT.
  - WAIT: on data_ok, capture the aligned/extended result and go to DONE.
  - DONE: ready_go=1. When WB accepts, go to IDLE; if a new memory op is latched the same edge, go to REQ.
- Latency: op latched at edge T. Req is high from T+1. data_ok seen in cycle Y gives ms_to_ws_valid from Y+1. Minimum total is 3 cycles when addr_ok and data_ok each arrive first cycle.
- Bus outputs are held stable while req=1 and addr_ok=0.
- Lane offset off = addr[log2(DATA_W/8)-1:0].
- Store wstrb: size-width ones shifted left by off. wdata is the low size bytes of es_wdata replicated across all lanes.
- Load: rdata is shifted right by off*8, then the low 8/16/32/64 bits are sign- or zero-extended to DATA_W.
- Load address is passed unmasked; size 3 with DATA_W=32 is never issued by EX.
- Misalignment is EX's exception and never reaches this block.
- ms_fwd_ready = ms_valid && ready_go.
- ID stalls when ms_fwd_we && dest matches && !ms_fwd_ready.
- Flush (highest priority):
  - ms_valid goes to 0 and no new instruction is latched that cycle.
  - IDLE or DONE: go to IDLE.
  - REQ without addr_ok the same cycle: req is withdrawn, go to IDLE.
  - REQ with addr_ok the same cycle, or WAIT without data_ok: go to DROP.
  - WAIT with data_ok the same cycle: data is discarded, go to IDLE.
- DROP: req=0 and ms_allowin=0. On data_ok, go to IDLE; the data is discarded and no WB write occurs.
- ws_allowin=0 while in DONE: the result and all outputs are held unchanged.

Test Plan:
- DATA_W=32, load byte signed at addr 0x1003, rdata 0x80AA_BB11; addr_ok and data_ok each 1 cycle after req -> result 0xFFFF_FF80 on ms_final_result, ms_to_ws_valid 3 cycles after latch.
- Store half at addr 0x2002, es_wdata 0x0000_1234 -> one req with wr=1, wstrb 4'b1100, wdata 0x1234_1234; completes on data_ok.
- Load word with addr_ok delayed 4 cycles and data_ok 3 cycles later -> req and addr held stable throughout. ms_fwd_ready=0 until the cycle after data_ok.
- Flush in WAIT, data_ok 2 cycles later -> ms_allowin=0 until data_ok. No ms_to_ws_valid. The next EX op is latched the cycle after data_ok.
- DATA_W=64, load word unsigned at addr 0x...4, rdata 0xDEAD_BEEF_0000_0001 -> result 0x0000_0000_DEAD_BEEF.
- Back-to-back ALU op then load with ws_allowin=0 for 2 cycles -> ALU result held stable. The load is not latched until WB accepts the ALU op.
